mem_bist: RTL and testbench

Parametrised built-in self-test controller for the external memory ports of the four-port RAM interface. It generalises the fixed constant-pattern pass/fail check to configurable data/address width, address range, pattern mode, read pipelining, read-timeout detection and error logging. It sits between top-level control (keys, ISSP, status LEDs) and one write/read port pair of the RAM interface.

---
 rtl/mem_bist.sv | 196 +++++++++++++++++++
 tb/tb_mem_bist.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_bist.sv
// mem_bist: built-in self-test controller for one write/read port pair of the
// four-port RAM interface. A test writes NUM_WORDS words starting at
// START_ADDR using a selectable pattern. It then reads them back with up to
// MAX_OUTSTANDING reads in flight and compares each return in order.
// Mismatches are counted and the first one is logged. A read that has not
// returned after TIMEOUT idle cycles ends the test with a timeout.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   start, mode           start pulse (IDLE/DONE only); pattern mode latched on start
//   wr_rdy/wr_en/wr_addr/wr_data         write request port
//   rd_rdy/rd_en/rd_addr                 read request port
//   rd_data/rd_data_valid                read return
//   busy, pass, fail, timeout            status
//   err_cnt, fail_addr, fail_data        error count (saturating), first mismatch
module mem_bist #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH      = 24,
  parameter int unsigned START_ADDR      = 0,
  parameter int unsigned NUM_WORDS       = 6,
  parameter logic [31:0] PATTERN         = 32'h00FFFFFF,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned TIMEOUT         = 1023
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic                  wr_rdy,
  input  logic                  rd_rdy,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_data_valid,
  output logic                  busy,
  output logic                  pass,
  output logic                  fail,
  output logic                  timeout,
  output logic [15:0]           err_cnt,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data
);

  localparam int unsigned CW = $clog2(NUM_WORDS + 1);
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [ADDR_WIDTH-1:0] BASE       = ADDR_WIDTH'(START_ADDR);
  localparam logic [CW-1:0]         LAST       = CW'(NUM_WORDS - 1);
  localparam logic [CW-1:0]         TOTAL      = CW'(NUM_WORDS);
  localparam logic [3:0]            MAX_OUT    = 4'(MAX_OUTSTANDING);
  localparam logic [TW-1:0]         IDLE_LIMIT = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  state_t          state;
  logic [1:0]      mode_q;
  logic [CW-1:0]   wr_cnt, rd_cnt, cmp_cnt, cmp_nxt;
  logic [3:0]      outstanding, out_nxt;
  logic [TW-1:0]   idle_cnt;
  logic            logged;
  logic [ADDR_WIDTH-1:0] wr_cur, rd_cur, cmp_addr;
  logic [DATA_WIDTH-1:0] expected;
  logic            cmp_ok, spurious, mismatch, fail_nxt;

  function automatic logic [DATA_WIDTH-1:0] pat(input logic [1:0] m,
                                                input logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] p;
    p = '0;
    case (m)
      2'd0: p = DATA_WIDTH'(PATTERN);
      2'd1: p = DATA_WIDTH'(a);
      2'd2: p = DATA_WIDTH'(1) << (a % DATA_WIDTH);
      default: begin
        // even address: 1010..., odd address: 0101...
        for (int unsigned i = 0; i < DATA_WIDTH; i++) p[i] = i[0] ^ a[0];
      end
    endcase
    return p;
  endfunction

  always_comb begin
    wr_cur   = BASE + ADDR_WIDTH'(wr_cnt);
    rd_cur   = BASE + ADDR_WIDTH'(rd_cnt);
    cmp_addr = BASE + ADDR_WIDTH'(cmp_cnt);
    busy     = (state == WRITE) || (state == READ) || (state == DRAIN);
    wr_en    = (state == WRITE) && wr_rdy;
    rd_en    = (state == READ) && rd_rdy && (outstanding < MAX_OUT);
    wr_addr  = (state == WRITE) ? wr_cur : '0;
    wr_data  = (state == WRITE) ? pat(mode_q, wr_cur) : '0;
    rd_addr  = (state == READ) ? rd_cur : '0;
    expected = pat(mode_q, cmp_addr);
    cmp_ok   = rd_data_valid && (outstanding != '0) &&
               ((state == READ) || (state == DRAIN));
    spurious = rd_data_valid && !cmp_ok;
    mismatch = cmp_ok && (rd_data != expected);
    out_nxt  = outstanding;
    if (rd_en && !cmp_ok)      out_nxt = outstanding + 4'd1;
    else if (!rd_en && cmp_ok) out_nxt = outstanding - 4'd1;
    cmp_nxt  = cmp_ok ? cmp_cnt + CW'(1) : cmp_cnt;
    fail_nxt = fail || mismatch || spurious;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      mode_q      <= '0;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      cmp_cnt     <= '0;
      outstanding <= '0;
      idle_cnt    <= '0;
      logged      <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout     <= 1'b0;
      err_cnt     <= '0;
      fail_addr   <= '0;
      fail_data   <= '0;
    end else begin
      // Error accounting runs in every state so stray returns are always seen.
      if (mismatch || spurious) begin
        if (err_cnt != '1) err_cnt <= err_cnt + 16'd1;
        fail <= 1'b1;
      end
      if (mismatch && !logged) begin
        logged    <= 1'b1;
        fail_addr <= cmp_addr;
        fail_data <= rd_data;
      end
      outstanding <= out_nxt;
      cmp_cnt     <= cmp_nxt;

      case (state)
        IDLE, DONE: begin
          if (start) begin
            pass        <= 1'b0;
            fail        <= 1'b0;
            timeout     <= 1'b0;
            err_cnt     <= '0;
            fail_addr   <= '0;
            fail_data   <= '0;
            logged      <= 1'b0;
            mode_q      <= mode;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            cmp_cnt     <= '0;
            outstanding <= '0;
            idle_cnt    <= '0;
            state       <= WRITE;
          end
        end
        WRITE: begin
          if (wr_en) begin
            wr_cnt <= wr_cnt + CW'(1);
            if (wr_cnt == LAST) state <= READ;
          end
        end
        READ: begin
          if (rd_en) begin
            rd_cnt <= rd_cnt + CW'(1);
            if (rd_cnt == LAST) state <= DRAIN;
          end
        end
        DRAIN: begin
          // Looks at post-edge values so DONE lands on the final compare edge.
          if (out_nxt == '0 && cmp_nxt == TOTAL) begin
            state <= DONE;
            pass  <= ~fail_nxt;
          end
        end
        default: state <= IDLE;
      endcase

      // Placed after the state case so a timeout overrides any other transition.
      if (state == READ || state == DRAIN) begin
        if (rd_en || rd_data_valid) begin
          idle_cnt <= '0;
        end else if (outstanding != '0) begin
          if (idle_cnt == IDLE_LIMIT) begin
            timeout     <= 1'b1;
            fail        <= 1'b1;
            pass        <= 1'b0;
            outstanding <= '0;
            idle_cnt    <= '0;
            state       <= DONE;
          end else begin
            idle_cnt <= idle_cnt + TW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_bist.sv
module tb_mem_bist;
  localparam int DW   = 32;
  localparam int AW   = 24;
  localparam int MAXO = 2;

  logic          clk = 1'b0;
  logic          reset, start, wr_rdy, rd_rdy, wr_en, rd_en, rd_data_valid;
  logic [1:0]    mode;
  logic [AW-1:0] wr_addr, rd_addr, fail_addr;
  logic [DW-1:0] wr_data, rd_data, fail_data;
  logic          busy, pass, fail, timeout;
  logic [15:0]   err_cnt;

  int checks = 0;
  int errors = 0;

  mem_bist #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .START_ADDR(0), .NUM_WORDS(6),
             .PATTERN(32'h00FFFFFF), .MAX_OUTSTANDING(MAXO), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .wr_rdy(wr_rdy), .rd_rdy(rd_rdy), .wr_en(wr_en), .rd_en(rd_en),
    .wr_addr(wr_addr), .rd_addr(rd_addr), .wr_data(wr_data),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .busy(busy), .pass(pass), .fail(fail), .timeout(timeout),
    .err_cnt(err_cnt), .fail_addr(fail_addr), .fail_data(fail_data));

  always #5 clk = ~clk;

  // Memory model: echoes writes, returns reads three cycles after issue,
  // optionally corrupting two addresses or dropping one response.
  logic [DW-1:0] mem [16];
  logic [1:0]    vsr;
  logic [DW-1:0] dsr0, dsr1, model_dat;
  logic          model_vld;
  logic          inj = 1'b0;
  int            corrupt_a = -1, corrupt_b = -1, drop_idx = -1;
  logic [DW-1:0] corrupt_val = '0;
  int            tb_out, wr_seen, rd_seen;
  logic [DW-1:0] w0, w5;
  logic          out_ovf = 1'b0;
  int            cyc = 0, last_act = 0;

  assign rd_data_valid = model_vld | inj;
  assign rd_data       = model_dat;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      vsr <= '0; dsr0 <= '0; dsr1 <= '0; model_vld <= 1'b0; model_dat <= '0;
      tb_out <= 0; wr_seen <= 0; rd_seen <= 0; w0 <= '0; w5 <= '0;
    end else begin
      if (wr_en) mem[wr_addr[3:0]] <= wr_data;
      vsr[1]    <= vsr[0];
      dsr1      <= dsr0;
      vsr[0]    <= rd_en && (int'(rd_addr) != drop_idx);
      dsr0      <= (int'(rd_addr) == corrupt_a || int'(rd_addr) == corrupt_b) ?
                   corrupt_val : mem[rd_addr[3:0]];
      model_vld <= vsr[1];
      model_dat <= dsr1;
      if (rd_en && tb_out >= MAXO) out_ovf <= 1'b1;
      if (start && !busy) begin
        tb_out <= 0; wr_seen <= 0; rd_seen <= 0; w0 <= '0; w5 <= '0;
      end else begin
        tb_out <= tb_out + (rd_en ? 1 : 0) - ((rd_data_valid && tb_out > 0) ? 1 : 0);
        if (wr_en) wr_seen <= wr_seen + 1;
        if (rd_en) rd_seen <= rd_seen + 1;
        if (wr_en && wr_addr == 0) w0 <= wr_data;
        if (wr_en && wr_addr == 5) w5 <= wr_data;
      end
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en || rd_data_valid) last_act <= cyc;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run(input logic [1:0] m, input bit rnd);
    int n;
    @(negedge clk); mode = m; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    n = 0;
    while (busy && n < 3000) begin
      if (rnd) begin
        wr_rdy = 1'($urandom_range(0, 1));
        rd_rdy = 1'($urandom_range(0, 1));
        if (n == 10) start = 1'b1;   // ignored while busy
        else start = 1'b0;
        if (n == 10) mode = 2'd2;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0; wr_rdy = 1'b1; rd_rdy = 1'b1;
    chk("done_in_time", {31'd0, busy}, 32'd0);
  endtask

  typedef struct {
    logic [1:0]  mode;
    int          ca, cb;
    logic [31:0] cval, w0, w5;
    logic        pass, fail;
    logic [15:0] err;
    logic [23:0] faddr;
    logic [31:0] fdata;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n;
    vecs[0] = '{2'd0, -1, -1, 32'h0, 32'h00FFFFFF, 32'h00FFFFFF, 1'b1, 1'b0, 16'd0, 24'd0, 32'd0};
    vecs[1] = '{2'd1, -1, -1, 32'h0, 32'h0,        32'h5,        1'b1, 1'b0, 16'd0, 24'd0, 32'd0};
    vecs[2] = '{2'd2, -1, -1, 32'h0, 32'h1,        32'h20,       1'b1, 1'b0, 16'd0, 24'd0, 32'd0};
    vecs[3] = '{2'd3, -1, -1, 32'h0, 32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b0, 16'd0, 24'd0, 32'd0};
    vecs[4] = '{2'd1,  2, -1, 32'h0, 32'h0,        32'h5,        1'b0, 1'b1, 16'd1, 24'd2, 32'h0};
    vecs[5] = '{2'd2,  3, -1, 32'hDEADBEEF, 32'h1, 32'h20,       1'b0, 1'b1, 16'd1, 24'd3, 32'hDEADBEEF};
    vecs[6] = '{2'd3,  1,  4, 32'h12345678, 32'hAAAAAAAA, 32'h55555555, 1'b0, 1'b1, 16'd2, 24'd1, 32'h12345678};

    reset = 1'b1; start = 1'b0; mode = 2'd0; wr_rdy = 1'b1; rd_rdy = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_strobes", {30'd0, wr_en, rd_en}, 32'd0);
    chk("rst_status", {29'd0, pass, fail, timeout}, 32'd0);
    chk("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
    chk("rst_fail_addr", {8'd0, fail_addr}, 32'd0);
    chk("rst_fail_data", fail_data, 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      corrupt_a = vecs[i].ca; corrupt_b = vecs[i].cb; corrupt_val = vecs[i].cval;
      run(vecs[i].mode, 1'b0);
      chk($sformatf("v%0d_writes", i), wr_seen, 32'd6);
      chk($sformatf("v%0d_reads", i), rd_seen, 32'd6);
      chk($sformatf("v%0d_wdata0", i), w0, vecs[i].w0);
      chk($sformatf("v%0d_wdata5", i), w5, vecs[i].w5);
      chk($sformatf("v%0d_pass", i), {31'd0, pass}, {31'd0, vecs[i].pass});
      chk($sformatf("v%0d_fail", i), {31'd0, fail}, {31'd0, vecs[i].fail});
      chk($sformatf("v%0d_timeout", i), {31'd0, timeout}, 32'd0);
      chk($sformatf("v%0d_err_cnt", i), {16'd0, err_cnt}, {16'd0, vecs[i].err});
      chk($sformatf("v%0d_fail_addr", i), {8'd0, fail_addr}, {8'd0, vecs[i].faddr});
      chk($sformatf("v%0d_fail_data", i), fail_data, vecs[i].fdata);
    end
    corrupt_a = -1; corrupt_b = -1;

    // Spurious returns after a passing test.
    run(2'd0, 1'b0);
    chk("pre_spur_pass", {31'd0, pass}, 32'd1);
    for (int k = 1; k <= 2; k++) begin
      inj = 1'b1; @(negedge clk); inj = 1'b0; @(negedge clk);
      chk($sformatf("spur%0d_err_cnt", k), {16'd0, err_cnt}, k);
      chk($sformatf("spur%0d_fail", k), {31'd0, fail}, 32'd1);
      chk($sformatf("spur%0d_fail_addr", k), {8'd0, fail_addr}, 32'd0);
      chk($sformatf("spur%0d_busy", k), {31'd0, busy}, 32'd0);
    end

    // Dropped response for word 4 -> timeout.
    drop_idx = 4;
    run(2'd0, 1'b0);
    chk("to_timeout", {31'd0, timeout}, 32'd1);
    chk("to_fail", {31'd0, fail}, 32'd1);
    chk("to_pass", {31'd0, pass}, 32'd0);
    chk("to_err_cnt", {16'd0, err_cnt}, 32'd0);
    chk("to_latency", cyc - 1 - last_act, 32'd15);
    drop_idx = -1;

    // Random readys, reset in the middle of the read phase, then restart.
    @(negedge clk); mode = 2'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (rd_seen < 2 && n < 500) begin
      wr_rdy = 1'($urandom_range(0, 1));
      rd_rdy = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    chk("reached_read", {31'd0, rd_seen >= 2}, 32'd1);
    wr_rdy = 1'b1; rd_rdy = 1'b1;
    reset = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_strobes", {30'd0, wr_en, rd_en}, 32'd0);
    chk("midrst_status", {29'd0, pass, fail, timeout}, 32'd0);
    chk("midrst_err_cnt", {16'd0, err_cnt}, 32'd0);
    chk("midrst_addrs", {8'd0, rd_addr | wr_addr}, 32'd0);
    @(negedge clk); reset = 1'b0;
    run(2'd1, 1'b1);
    chk("restart_pass", {31'd0, pass}, 32'd1);
    chk("restart_fail", {31'd0, fail}, 32'd0);
    chk("restart_err_cnt", {16'd0, err_cnt}, 32'd0);
    chk("restart_wdata5", w5, 32'h5);
    chk("outstanding_limit", {31'd0, out_ovf}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
